// File: rtl/count1k_pkg.sv
// Shared constants and state encoding for the modulo-1000 interval timer.
package count1k_pkg;

    localparam int MOD_DEF = 1000;
    localparam int W_DEF   = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/count1k_core.sv
// W-bit up-counter datapath; clear has priority over increment.
module count1k_core #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/count1k_timer_ctrl.sv
// Interval timer controller: runs the shared counter from 0 to len_eff-1 and
// pulses done at each interval end, one-shot or periodic.
//
//   state | meaning
//   IDLE  | waiting for a request, counter held at 0, req_ready high
//   RUN   | counting toward len_eff-1, busy high
module count1k_timer_ctrl
    import count1k_pkg::*;
#(
    parameter int MOD = MOD_DEF,
    parameter int W   = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_len,
    input  logic         req_periodic,
    input  logic         hold,
    input  logic         abort,
    output logic [W-1:0] q,
    output logic         done,
    output logic         busy
);

    localparam logic [W-1:0] LEN_MAX_M1 = W'(MOD - 1);

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] len_m1_r;
    logic [W-1:0] len_m1_in;
    logic         periodic_r;
    logic         accept;
    logic         terminal;
    logic         clr;
    logic         en;
    logic         done_nxt;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign terminal  = (q == len_m1_r);

    // Out-of-range lengths (0 or above MOD) run a full modulus period.
    assign len_m1_in = (req_len == '0 || 32'(req_len) > MOD) ? LEN_MAX_M1
                                                              : req_len - W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            len_m1_r   <= LEN_MAX_M1;
            periodic_r <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            busy  <= (state_nxt == RUN);
            if (accept) begin
                len_m1_r   <= len_m1_in;
                periodic_r <= req_periodic;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) state_nxt = RUN;
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (!hold && terminal && !periodic_r) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        clr      = 1'b0;
        en       = 1'b0;
        done_nxt = 1'b0;
        case (state)
            IDLE: begin
                clr = 1'b1;
            end
            RUN: begin
                en = !hold;
                if (abort) begin
                    clr = 1'b1;
                end else if (!hold && terminal) begin
                    clr      = 1'b1;
                    done_nxt = 1'b1;
                end
            end
            default: clr = 1'b1;
        endcase
        if (reset) clr = 1'b1;
    end

    count1k_core #(.W(W)) u_core (
        .clk (clk),
        .clr (clr),
        .en  (en),
        .q   (q)
    );

endmodule
